// File: rtl/trakball_pkg.sv
//------------------------------------------------------------------------------
// Module   : trakball_pkg
// Purpose  : Shared types, Gray-sequence constants and helpers for the
//            Centipede trackball quadrature front end.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package trakball_pkg;

   localparam int c_cnt_w = 4;

   typedef logic signed [2:0] delta_t;
   typedef logic        [1:0] qstate_t;

   // {A,B} states in forward order; stepping forward through them is +1
   localparam qstate_t c_q_s0 = 2'b00;
   localparam qstate_t c_q_s1 = 2'b01;
   localparam qstate_t c_q_s2 = 2'b11;
   localparam qstate_t c_q_s3 = 2'b10;

   function automatic logic [1:0] gray_pos(input qstate_t s);
      logic [1:0] p;
      case (s)
         c_q_s0:  p = 2'd0;
         c_q_s1:  p = 2'd1;
         c_q_s2:  p = 2'd2;
         default: p = 2'd3;
      endcase
      return p;
   endfunction

   function automatic delta_t emu_delta(input logic tick, input logic inc, input logic dec);
      delta_t d;
      d = '0;
      if (tick && inc && !dec)
         d = 3'sd1;
      else if (tick && dec && !inc)
         d = -3'sd1;
      return d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/qdec_axis.sv
//------------------------------------------------------------------------------
// Module   : qdec_axis
// Purpose  : One quadrature axis: synchroniser, optional glitch filter
//            (TRAKBALL_FILTER_EN), init capture, decode and illegal flag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module qdec_axis
   import trakball_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic   clk_12mhz,
   input  logic   reset_n,
   input  logic   i_qa,
   input  logic   i_qb,
   output delta_t o_delta,
   output logic   o_err
);

`ifdef TRAKBALL_FILTER_EN
   localparam int c_use_filt = 1;
`else
   localparam int c_use_filt = 0;
`endif
   // init stays set until the first real sample has crossed the whole pipeline
   localparam int c_fill = SYNC_STAGES + 1 + c_use_filt * FILT_LEN;

   qstate_t [SYNC_STAGES-1:0] r_sync;
   qstate_t                   w_sync;
   qstate_t                   w_state;
   qstate_t                   r_prev;
   logic    [c_fill-1:0]      r_fill;
   logic                      w_init;
   logic    [1:0]             w_step;
   delta_t                    w_delta;
   logic                      w_illegal;
   delta_t                    r_delta;
   logic                      r_err;

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n)
         r_sync <= '0;
      else
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_qa, i_qb};
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef TRAKBALL_FILTER_EN
   localparam int c_fcnt_w = $clog2(FILT_LEN);

   for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic [c_fcnt_w-1:0] r_fcnt;
      logic                r_out;

      always_ff @(posedge clk_12mhz or negedge reset_n) begin
         if (!reset_n) begin
            r_fcnt <= '0;
            r_out  <= 1'b0;
         end else if (w_sync[gi] == r_out) begin
            r_fcnt <= '0;
         end else if (r_fcnt == c_fcnt_w'(FILT_LEN - 1)) begin
            r_fcnt <= '0;
            r_out  <= w_sync[gi];
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end

      assign w_state[gi] = r_out;
   end
`else
   assign w_state = w_sync;
`endif

   assign w_init = ~r_fill[c_fill-1];

   always_comb begin
      w_delta   = '0;
      w_illegal = 1'b0;
      w_step    = gray_pos(w_state) - gray_pos(r_prev);
      case (w_step)
         2'd1:    w_delta   = 3'sd1;
         2'd3:    w_delta   = -3'sd1;
         2'd2:    w_illegal = 1'b1;
         default: w_delta   = '0;
      endcase
   end

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_fill  <= '0;
         r_prev  <= '0;
         r_delta <= '0;
         r_err   <= 1'b0;
      end else begin
         r_fill <= {r_fill[c_fill-2:0], 1'b1};
         r_prev <= w_state;
         if (w_init) begin
            r_delta <= '0;
            r_err   <= 1'b0;
         end else begin
            r_delta <= w_delta;
            r_err   <= w_illegal;
         end
      end
   end

   assign o_delta = r_delta;
   assign o_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/trakball_qdec.sv
//------------------------------------------------------------------------------
// Module   : trakball_qdec
// Purpose  : Two-axis trackball decoder with joystick emulation feeding 4-bit
//            wrap-around position counters. Macro TRAKBALL_FILTER_EN adds a
//            glitch filter on every synchronised phase.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trakball_qdec
   import trakball_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int EMU_DIV     = 20000
) (
   input  logic       clk_12mhz,
   input  logic       reset_n,
   input  logic       qa_h,
   input  logic       qb_h,
   input  logic       qa_v,
   input  logic       qb_v,
   input  logic       emu_left,
   input  logic       emu_right,
   input  logic       emu_up,
   input  logic       emu_down,
   output logic [7:0] trakball_o,
   output logic       h_dir,
   output logic       v_dir,
   output logic       step_h,
   output logic       step_v,
   output logic       err_o
);

   localparam int c_pre_w = $clog2(EMU_DIV);

   delta_t               w_qd_h, w_qd_v;
   delta_t               w_ed_h, w_ed_v;
   delta_t               w_sum_h, w_sum_v;
   logic                 w_err_h, w_err_v;
   logic                 w_tick;
   logic [c_pre_w-1:0]   r_presc;
   logic [c_cnt_w-1:0]   r_h_cnt, r_v_cnt;
   logic                 r_h_dir, r_v_dir;
   logic                 r_step_h, r_step_v;
   logic                 r_err;

   qdec_axis #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_axis_h (
      .clk_12mhz (clk_12mhz),
      .reset_n   (reset_n),
      .i_qa      (qa_h),
      .i_qb      (qb_h),
      .o_delta   (w_qd_h),
      .o_err     (w_err_h)
   );

   qdec_axis #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_axis_v (
      .clk_12mhz (clk_12mhz),
      .reset_n   (reset_n),
      .i_qa      (qa_v),
      .i_qb      (qb_v),
      .o_delta   (w_qd_v),
      .o_err     (w_err_v)
   );

   assign w_tick = (r_presc == c_pre_w'(EMU_DIV - 1));

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n)
         r_presc <= '0;
      else if (w_tick)
         r_presc <= '0;
      else
         r_presc <= r_presc + 1'b1;
   end

   assign w_ed_h  = emu_delta(w_tick, emu_right, emu_left);
   assign w_ed_v  = emu_delta(w_tick, emu_up, emu_down);
   // -2..+2 fits the 3-bit signed delta, so the sum cannot overflow
   assign w_sum_h = w_qd_h + w_ed_h;
   assign w_sum_v = w_qd_v + w_ed_v;

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_h_cnt  <= '0;
         r_v_cnt  <= '0;
         r_h_dir  <= 1'b0;
         r_v_dir  <= 1'b0;
         r_step_h <= 1'b0;
         r_step_v <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_h_cnt  <= r_h_cnt + c_cnt_w'(w_sum_h);
         r_v_cnt  <= r_v_cnt + c_cnt_w'(w_sum_v);
         r_step_h <= (w_sum_h != '0);
         r_step_v <= (w_sum_v != '0);
         if (w_sum_h != '0)
            r_h_dir <= w_sum_h[2];
         if (w_sum_v != '0)
            r_v_dir <= w_sum_v[2];
         r_err <= r_err | w_err_h | w_err_v;
      end
   end

   assign trakball_o = {r_v_cnt, r_h_cnt};
   assign h_dir      = r_h_dir;
   assign v_dir      = r_v_dir;
   assign step_h     = r_step_h;
   assign step_v     = r_step_v;
   assign err_o      = r_err;

endmodule

`default_nettype wire

// File: doc/trakball_qdec.md
# trakball_qdec

Trackball and joystick-emulation front end for the Centipede core. Two quadrature axes (horizontal, vertical) are synchronised, optionally glitch-filtered, and decoded into signed steps that drive wrap-around 4-bit position counters. A digital-joystick emulator adds steps on the same counters. The packed result drives the `trakball_i` input of `centipede`.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops per quadrature input (≥2).
- `FILT_LEN`, default 4: stable cycles required by the glitch filter (≥2; used only with the filter macro).
- `EMU_DIV`, default 20000: prescaler period for emulated steps (≥2; 600 steps/s at 12 MHz).
- `clk_12mhz` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `qa_h`, `qb_h` in 1 each: horizontal quadrature phases; asynchronous.
- `qa_v`, `qb_v` in 1 each: vertical quadrature phases; asynchronous.
- `emu_left`, `emu_right`, `emu_up`, `emu_down` in 1 each: active-high joystick emulation requests; synchronous.
- `trakball_o` out 8: {v_cnt[3:0], h_cnt[3:0]}.
- `h_dir`, `v_dir` out 1 each: last nonzero step direction per axis; 0 = positive, 1 = negative.
- `step_h`, `step_v` out 1 each: one-cycle pulse on the cycle the axis counter changes.
- `err_o` out 1: sticky illegal-transition flag.

## Operation
- **Reset (async assert):** all counters 0, `h_dir`/`v_dir` 0, `step_*` 0, `err_o` 0, synchroniser/filter regs 0, prescaler 0, both `init` flags set.
- **Per-axis quadrature state** is {A,B} after sync (and filter).
  - Sequence 00→01→11→10→00 is +1; the reverse is −1.
  - No change gives 0.
  - A two-bit change (00↔11, 01↔10) is illegal: delta 0, `err_o` set, previous state still updated.
- **First sample after reset:** while `init` is set, the decoded state is loaded into prev with no count and no error, then `init` clears.
- **Emulation:** the prescaler counts 0..EMU_DIV−1 and wraps; `tick` is asserted when it equals EMU_DIV−1.
  - On `tick`: `emu_right` gives h +1 and `emu_left` gives h −1; both or neither give 0.
  - Vertical uses `emu_up` (+1) and `emu_down` (−1) with the same rule.
- **Combining:** per-axis delta = quadrature delta + emulated delta, signed range −2..+2.
  - The counter adds delta modulo 16 (15+1→0, 0−1→15, 15+2→1).
  - `dir` updates only when delta ≠ 0.
  - Opposite simultaneous steps cancel: delta 0, no `step` pulse, `dir` unchanged.
- **err_o** clears only on reset.

## Timing
- Without the filter, an input edge reaches the counter and `step` SYNC_STAGES+1 clocks after the first sampling edge.
- With the filter, latency is SYNC_STAGES+FILT_LEN+1 clocks.
- Emulated step: the counter changes one clock after the `tick` cycle.
- Counters, `dir`, `step` and `err_o` are all registered outputs with no combinational input-to-output path.
- Both axes update in the same cycle independently.
- Reset deasserted mid-motion: the first post-reset state is captured by `init` and never counted.

## Configuration
- Macro: `TRAKBALL_FILTER_EN`.
- **Defined:** each synchronised phase passes through a stability filter. The output changes only after the input has held a new value for FILT_LEN consecutive clocks. Pulses shorter than FILT_LEN are discarded.
- **Undefined:** the synchronised phases feed the decoder directly and `FILT_LEN` is ignored.

## Structure
- **Shared package `trakball_pkg`:**
  - signed 3-bit delta typedef;
  - 2-bit quadrature state typedef;
  - Gray-sequence constants;
  - counter width constant (4).
- **Sub-module `qdec_axis`**, instantiated twice. It contains the synchroniser, the optional filter, `init`/prev state, the decode and the illegal-transition flag, and outputs a quadrature delta plus an `err` pulse.
- The top level holds the shared prescaler, emulation decode, delta summation, counters, `dir` and `step` registers.

## Test plan
- **Reset and init:** hold `qa_h`=1, `qb_h`=1 through reset release. Expect `trakball_o`=0x00, `err_o`=0, no `step_h`.
- **Forward and backward:** drive h 00→01→11→10→00 repeated 17 times. Expect h_cnt=4 (68 mod 16), `h_dir`=0, 68 `step_h` pulses. Reverse 5 steps: expect h_cnt=15, `h_dir`=1.
- **Illegal jump:** on v, drive 00→11. Expect v_cnt unchanged, `err_o`=1 and still 1 after further legal steps. Reset clears it.
- **Emulation with wrap:** EMU_DIV=4, `emu_down` held for 3 ticks from v_cnt=1. Expect v_cnt 0, 15, 14, `v_dir`=1. Both `emu_up` and `emu_down` held gives no change.
- **Simultaneous:** a quadrature +1 on h in the same cycle as an emulated right tick gives h_cnt +2 and one `step_h` pulse. Quadrature −1 with a right tick gives no change, no pulse, and `h_dir` held.
- **Filter (macro defined, FILT_LEN=4):** a 3-clock glitch on `qa_h` gives no count. A 4-clock hold gives +1 at latency SYNC_STAGES+5.
